// File: rtl/booth_mul_seq_pkg.sv
// Shared types and recoding helpers for the sequential Booth multiplier.
//   state_t    : control FSM states
//   booth_op_t : datapath operation selected by Booth recoding
//   recode_r2  : radix-2 recoding of {q0, qm}
//   recode_r4  : radix-4 (modified Booth) recoding of {q1, q0, qm}
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD_M,
        OP_SUB_M,
        OP_ADD_2M,
        OP_SUB_2M
    } booth_op_t;

    function automatic booth_op_t recode_r2(input logic [1:0] bits);
        booth_op_t op;
        case (bits)
            2'b01:   op = OP_ADD_M;
            2'b10:   op = OP_SUB_M;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    function automatic booth_op_t recode_r4(input logic [2:0] bits);
        booth_op_t op;
        case (bits)
            3'b001, 3'b010: op = OP_ADD_M;
            3'b011:         op = OP_ADD_2M;
            3'b100:         op = OP_SUB_2M;
            3'b101, 3'b110: op = OP_SUB_M;
            default:        op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// Operand / product handshake bundle for booth_mul_seq.
//   in_valid, in_ready          : operand channel (valid/ready)
//   multiplicand, multiplier    : WIDTH-bit two's complement operands
//   out_valid, out_ready        : product channel (valid/ready)
//   product                     : 2*WIDTH-bit signed product
//   busy                        : multiplier has an operation in flight
// master = operand issuer / result collector, slave = the multiplier.
interface booth_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_mul_seq_dp.sv
// Booth datapath: M / A / Q / qm registers, add/sub unit and arithmetic shifter.
//   clk, rst_n         : clock, async active-low reset (clears all registers)
//   capture            : latch multiplicand into M and multiplier into Q
//   load               : clear A and qm before the first iteration
//   shift              : apply op to A, then shift {A,Q,qm} right by 1 or 2
//   op                 : operation chosen by the recoder
//   rbits              : {Q[1], Q[0], qm} for the recoder
//   product            : {A[WIDTH-1:0], Q}
module booth_dp
    import booth_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit RADIX4 = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 load,
    input  logic                 shift,
    input  booth_op_t            op,
    output logic [2:0]           rbits,
    output logic [2*WIDTH-1:0]   product
);
    // Two guard bits on A keep +-2M from overflowing in radix-4 mode.
    localparam int AW = WIDTH + 2;
    localparam int SH = RADIX4 ? 2 : 1;
    localparam int VW = AW + WIDTH + 1;

    logic [AW-1:0]    a_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] q_q;
    logic             qm_q;

    logic [AW-1:0]    m1;
    logic [AW-1:0]    m2;
    logic [AW-1:0]    a_sum;
    logic [VW-1:0]    vec;
    logic [VW-1:0]    vec_sh;

    always_comb begin
        m1 = {{2{m_q[WIDTH-1]}}, m_q};
        m2 = {m_q[WIDTH-1], m_q, 1'b0};
        case (op)
            OP_ADD_M:  a_sum = a_q + m1;
            OP_SUB_M:  a_sum = a_q - m1;
            OP_ADD_2M: a_sum = a_q + m2;
            OP_SUB_2M: a_sum = a_q - m2;
            default:   a_sum = a_q;
        endcase
        // Add and shift happen in the same cycle: shift the post-add value.
        vec    = {a_sum, q_q, qm_q};
        vec_sh = $signed(vec) >>> SH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            m_q  <= '0;
            q_q  <= '0;
            qm_q <= 1'b0;
        end else if (capture) begin
            m_q <= multiplicand;
            q_q <= multiplier;
        end else if (load) begin
            a_q  <= '0;
            qm_q <= 1'b0;
        end else if (shift) begin
            a_q  <= vec_sh[VW-1 -: AW];
            q_q  <= vec_sh[WIDTH:1];
            qm_q <= vec_sh[0];
        end
    end

    assign rbits   = {q_q[1:0], qm_q};
    assign product = {a_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed Booth multiplier, radix-2 or radix-4, with valid/ready
// handshakes on operands and product.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; discards any operation in flight
//   bus    : booth_mul_seq_if.slave (operand channel, product channel, busy)
// Parameters: WIDTH (>= 4, even when RADIX4), RADIX4 (0 = radix-2, 1 = radix-4).
// Timing: accept cycle, one LOAD cycle, ITERS ITER cycles, then DONE until the
// product is taken; one product per ITERS+3 cycles back to back.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit RADIX4 = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    booth_mul_seq_if.slave bus
);
    localparam int ITERS = RADIX4 ? WIDTH / 2 : WIDTH;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    if (WIDTH < 4 || (RADIX4 && (WIDTH % 2) != 0)) begin : g_bad_params
        $error("booth_mul_seq: WIDTH must be >= 4 and even when RADIX4=1");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    logic             in_ready;
    logic             out_valid;
    logic             capture;
    logic             load;
    logic             shift;
    logic [2:0]       rbits;
    booth_op_t        op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                cnt_q <= CNT_W'(ITERS - 1);
            end else if (state_q == ITER && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = ITER;
            end
            ITER: begin
                shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op = RADIX4 ? recode_r4(rbits) : recode_r2(rbits[1:0]);
    end

    booth_dp #(
        .WIDTH (WIDTH),
        .RADIX4(RADIX4)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (capture),
        .multiplicand(bus.multiplicand),
        .multiplier  (bus.multiplier),
        .load        (load),
        .shift       (shift),
        .op          (op),
        .rbits       (rbits),
        .product     (bus.product)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = (state_q != IDLE);

endmodule
